// File: rtl/program_loader.sv
// program_loader
//   Streams a 2**ADDR_WIDTH byte program image into the CPU's unified memory,
//   optionally verifies a trailing XOR checksum byte, and holds the CPU in
//   reset until the image is loaded and verified.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 one-cycle request to begin/restart a load
//   in_data/in_valid      byte stream; in_ready = loader accepts this cycle
//   mem_addr/mem_data     memory write port, mem_we strobes one cycle per byte
//   cpu_hold              1 = CPU held in reset
//   load_done/load_error  image verified / checksum mismatch
//   word_count            bytes written in the current load (0..DEPTH)
module program_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int CHECK_EN   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH-1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   WC_ONE    = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] csum;
  logic                  accept;
  logic                  restart;

  // All status outputs are pure decodes of the state register.
  assign in_ready   = (state == S_LOAD) || (state == S_CHECK);
  assign cpu_hold   = (state != S_DONE);
  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERROR);

  assign accept  = in_valid && in_ready;
  // start is only honoured outside an active load; in_ready is 0 in these
  // states, so a byte presented alongside start is never taken.
  assign restart = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (accept && (addr == ADDR_LAST))
          state_nxt = (CHECK_EN != 0) ? S_CHECK : S_DONE;
      end
      S_CHECK: begin
        if (accept) state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      csum       <= '0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= 1'b0;
      if (restart) begin
        addr       <= '0;
        csum       <= '0;
        word_count <= '0;
      end else if ((state == S_LOAD) && accept) begin
        mem_we     <= 1'b1;
        mem_addr   <= addr;
        mem_data   <= in_data;
        csum       <= csum ^ in_data;
        word_count <= word_count + WC_ONE;
        // Leaving LOAD on the last byte: park addr rather than wrap to 0.
        if (addr != ADDR_LAST) addr <= addr + ADDR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Scoreboard bench: a reference model updated at each rising edge pushes
//   the expected memory writes into a queue and predicts every status output;
//   a checker on the falling edge pops writes and compares all outputs.
//   A second instance built with CHECK_EN=0 gets a short directed check.
module tb_program_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;
  logic [5:0] word_count;

  logic       start2 = 1'b0;
  logic [7:0] in_data2 = 8'h00;
  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic [4:0] mem_addr2;
  logic [7:0] mem_data2;
  logic       mem_we2;
  logic       cpu_hold2;
  logic       load_done2;
  logic       load_error2;
  logic [5:0] word_count2;

  always #5 clock = ~clock;

  program_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .CHECK_EN(1)) dut (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error), .word_count(word_count)
  );

  program_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .CHECK_EN(0)) dut_nochk (
    .clock(clock), .reset(reset), .start(start2), .in_data(in_data2),
    .in_valid(in_valid2), .in_ready(in_ready2), .mem_addr(mem_addr2),
    .mem_data(mem_data2), .mem_we(mem_we2), .cpu_hold(cpu_hold2),
    .load_done(load_done2), .load_error(load_error2), .word_count(word_count2)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_CHECK = 2, M_DONE = 3, M_ERROR = 4;
  int          ms = M_IDLE;
  int          mcnt = 0;
  logic [7:0]  mcs = 8'h00;
  logic        exp_we = 1'b0;
  logic        after_rst = 1'b0;
  logic        armed = 1'b0;
  logic [12:0] wq[$];

  always @(posedge clock) begin
    logic rdy;
    rdy = (ms == M_LOAD) || (ms == M_CHECK);
    exp_we = 1'b0;
    after_rst = 1'b0;
    armed = 1'b1;
    if (reset) begin
      ms = M_IDLE; mcnt = 0; mcs = 8'h00; after_rst = 1'b1;
    end else begin
      case (ms)
        M_IDLE, M_DONE, M_ERROR:
          if (start) begin ms = M_LOAD; mcnt = 0; mcs = 8'h00; end
        M_LOAD:
          if (in_valid && rdy) begin
            wq.push_back({mcnt[4:0], in_data});
            exp_we = 1'b1;
            mcs = mcs ^ in_data;
            mcnt++;
            if (mcnt == 32) ms = M_CHECK;
          end
        M_CHECK:
          if (in_valid && rdy) ms = (in_data == mcs) ? M_DONE : M_ERROR;
        default: ms = M_IDLE;
      endcase
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      check("mem_we", mem_we, exp_we);
      if (mem_we) begin
        if (wq.size() == 0) check("unexpected_write", 1, 0);
        else begin
          logic [12:0] w;
          w = wq.pop_front();
          check("mem_addr", mem_addr, w[12:8]);
          check("mem_data", mem_data, w[7:0]);
        end
      end
      if (after_rst) begin
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
      end
      check("in_ready", in_ready, (ms == M_LOAD) || (ms == M_CHECK));
      check("cpu_hold", cpu_hold, ms != M_DONE);
      check("load_done", load_done, ms == M_DONE);
      check("load_error", load_error, ms == M_ERROR);
      check("word_count", word_count, mcnt);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] img[32];

  task automatic send_byte(input logic [7:0] d, input int gap);
    int n;
    repeat (gap) begin in_valid = 1'b0; @(negedge clock); end
    in_data = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) check("accept_timeout", 0, 1);
    else @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic load_image(input logic [7:0] ck, input int max_gap);
    pulse_start();
    for (int i = 0; i < 32; i++)
      send_byte(img[i], (i == 7 && max_gap > 0) ? 5 : $urandom_range(0, max_gap));
    send_byte(ck, 0);
    repeat (2) @(negedge clock);
  endtask

  int we2_cnt = 0;
  always @(posedge clock) if (mem_we2) we2_cnt++;

  initial begin
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0]  = 8'hFE;
    img[30] = 8'hE3;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // nominal load
    load_image(8'h1D, 0);
    check("nom_done", load_done, 1);
    check("nom_hold", cpu_hold, 0);
    check("nom_wc", word_count, 32);

    // bad checksum, then reload with the good one
    load_image(8'h1C, 0);
    check("bad_err", load_error, 1);
    check("bad_hold", cpu_hold, 1);
    load_image(8'h1D, 0);
    check("reload_done", load_done, 1);

    // backpressure with random gaps including a 5-cycle gap
    load_image(8'h1D, 3);
    check("bp_done", load_done, 1);

    // reset mid-load after 10 bytes
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(img[i], 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_wc", word_count, 0);
    // bytes offered in IDLE are ignored
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    load_image(8'h1D, 1);
    check("after_rst_done", load_done, 1);

    // start pulsed with byte 5 of a load is ignored
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(img[i], 0);
    start = 1'b1;
    send_byte(img[5], 0);
    start = 1'b0;
    check("start_in_load_wc", word_count, 6);
    for (int i = 6; i < 32; i++) send_byte(img[i], 0);
    send_byte(8'h1D, 0);
    repeat (2) @(negedge clock);
    check("start_in_load_done", load_done, 1);

    // start and in_valid together in DONE: byte must not be taken
    start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clock);
    start = 1'b0; in_valid = 1'b0;
    check("restart_wc", word_count, 0);
    for (int i = 0; i < 32; i++) send_byte(img[i], 0);
    send_byte(8'h1D, 0);
    repeat (2) @(negedge clock);
    check("restart_done", load_done, 1);
    check("queue_empty", wq.size(), 0);

    // CHECK_EN=0 instance
    check("nc_rst_hold", cpu_hold2, 1);
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    in_valid2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_data2 = 8'(i + 3);
      check("nc_ready", in_ready2, 1);
      @(negedge clock);
    end
    in_data2 = 8'h77;
    check("nc_ready_after", in_ready2, 0);
    check("nc_done", load_done2, 1);
    check("nc_hold", cpu_hold2, 0);
    check("nc_err", load_error2, 0);
    check("nc_last_we", mem_we2, 1);
    check("nc_last_addr", mem_addr2, 31);
    check("nc_last_data", mem_data2, 8'd34);
    repeat (3) @(negedge clock);
    in_valid2 = 1'b0;
    check("nc_wc", word_count2, 32);
    check("nc_we_cnt", we2_cnt, 32);
    check("nc_still_done", load_done2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the 8-bit CPU: streams a program image of 2**ADDR_WIDTH bytes into the CPU's unified instruction/data memory.
- Accepts bytes over a valid/ready handshake and writes them to consecutive addresses starting at 0.
- Optionally checks a trailing XOR checksum byte.
- Holds the CPU in reset until the image is loaded and verified, then releases it.

Parameters:
- DATA_WIDTH, 8, byte/word width of the stream and memory.
- ADDR_WIDTH, 5, memory address width; image length DEPTH = 2**ADDR_WIDTH (32).
- CHECK_EN, 1, 1 = expect a checksum byte after the image; 0 = no checksum phase.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin or restart a load.
- in_data  input  DATA_WIDTH  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_addr  output  ADDR_WIDTH  memory write address.
- mem_data  output  DATA_WIDTH  memory write data.
- mem_we  output  1  memory write strobe, one cycle per byte.
- cpu_hold  output  1  reset/hold to the CPU; 1 = CPU held.
- load_done  output  1  image loaded and verified.
- load_error  output  1  checksum mismatch.
- word_count  output  ADDR_WIDTH+1  bytes written in the current load, 0..DEPTH.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-load):
  - State IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, load_done=0, load_error=0, word_count=0.
  - Internal address and checksum cleared.
- Handshake:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready is a registered state decode: 1 only in LOAD and CHECK.
  - in_valid gaps of any length are legal; nothing advances without acceptance.
- Write path (1-cycle latency from accept to write):
  - On the cycle after an accept in LOAD: mem_we=1, mem_addr = address of the accepted byte, mem_data = accepted byte.
  - mem_we=0 in every other cycle.
  - mem_addr/mem_data hold their last values when mem_we=0.
- Checksum: csum <= csum ^ in_data on every accept in LOAD; cleared on entering LOAD.
- States:
  - IDLE: cpu_hold=1. start=1 -> LOAD and clears addr, csum, word_count, load_done, load_error.
  - LOAD: each accept increments addr and word_count.
    - Accept at addr=DEPTH-1 -> CHECK if CHECK_EN, else DONE.
    - addr never wraps within a load; word_count reaches DEPTH.
  - CHECK: accepts exactly one byte, not written to memory. Byte==csum -> DONE; otherwise -> ERROR.
  - DONE: load_done=1, cpu_hold=0, held until start or reset. start=1 -> LOAD with same clears and cpu_hold=1 next cycle.
  - ERROR: load_error=1, cpu_hold=1, held. start=1 -> LOAD with same clears.
- Boundary and simultaneous events:
  - start in LOAD or CHECK is ignored.
  - start and in_valid in the same IDLE/DONE/ERROR cycle: byte not accepted, since in_ready=0 that cycle.
  - cpu_hold deasserts on the same edge load_done asserts; the final mem_we pulse occurs at or before that edge.
  - Bytes presented in IDLE/DONE/ERROR are not accepted and have no effect.

Test Plan:
- Nominal load: start, then 32 bytes (addr 0x00=FE, 0x1E=E3, rest 00), then checksum 0x1D.
  -> 32 mem_we pulses at addresses 0x00..0x1F with matching data; word_count=32; load_done=1, cpu_hold=0, load_error=0.
- Bad checksum: same image, checksum 0x1C.
  -> 32 writes, then load_error=1, cpu_hold=1, load_done=0; a further start reloads and a correct 0x1D gives DONE.
- Backpressure: in_valid toggled randomly, including 5-cycle gaps.
  -> writes only on accepts, each exactly 1 cycle after its accept; addresses contiguous; final state DONE.
- Reset mid-load after 10 bytes (addr=0x0A).
  -> next cycle all outputs at reset values; a new start loads from addr 0 and completes normally.
- start pulsed at byte 5 of LOAD.
  -> ignored: addr and word_count continue 5->6, csum unaffected, load completes.
- CHECK_EN=0 build: 32 bytes.
  -> DONE immediately after the 32nd accept; the next in_valid byte is not accepted (in_ready=0).
